// File: rtl/koa_sched_pkg.sv
// koa_sched_pkg: shared types and constants for the KOA multiplier scheduler.
// Revision 1.0
`default_nettype none

package koa_sched_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_e;

  localparam int   CNT_W = 4;
  localparam logic REQ0  = 1'b0;
  localparam logic REQ1  = 1'b1;

endpackage

`default_nettype wire

// File: rtl/koa_fpga.sv
// KOA_FPGA: combinational one-level Karatsuba-Ofman multiplier, full 2*SW product.
// Revision 1.0
`default_nettype none

module KOA_FPGA #(
  parameter int SW = 54
) (
  input  logic [SW-1:0]   a_i,
  input  logic [SW-1:0]   b_i,
  output logic [2*SW-1:0] p_o
);

  localparam int L = SW / 2;
  localparam int H = SW - L;

  logic [H-1:0]     a_hi, b_hi;
  logic [L-1:0]     a_lo, b_lo;
  logic [H:0]       a_sum, b_sum;
  logic [2*H-1:0]   p_hh;
  logic [2*L-1:0]   p_ll;
  logic [2*H+1:0]   p_mm;
  logic [2*SW-1:0]  p_mid;

  assign a_hi  = a_i[SW-1:L];
  assign b_hi  = b_i[SW-1:L];
  assign a_lo  = a_i[L-1:0];
  assign b_lo  = b_i[L-1:0];
  assign a_sum = {1'b0, a_hi} + (H+1)'(a_lo);
  assign b_sum = {1'b0, b_hi} + (H+1)'(b_lo);
  assign p_hh  = (2*H)'(a_hi) * (2*H)'(b_hi);
  assign p_ll  = (2*L)'(a_lo) * (2*L)'(b_lo);
  assign p_mm  = (2*H+2)'(a_sum) * (2*H+2)'(b_sum);

  // (ah+al)(bh+bl) - ah*bh - al*bl is the cross term ah*bl + al*bh
  assign p_mid = (2*SW)'(p_mm) - (2*SW)'(p_hh) - (2*SW)'(p_ll);
  assign p_o   = ((2*SW)'(p_hh) << (2*L)) + (p_mid << L) + (2*SW)'(p_ll);

endmodule

`default_nettype wire

// File: rtl/koa_rr_arb2.sv
// koa_rr_arb2: two-way round-robin arbiter; on contention the requester that is not the pointer wins.
// Revision 1.0
`default_nettype none

module koa_rr_arb2
  import koa_sched_pkg::*;
(
  input  logic [1:0] valid_i,
  input  logic       ptr_i,
  input  logic       en_i,
  output logic [1:0] grant_o,
  output logic       id_o
);

  always_comb begin
    grant_o = 2'b00;
    id_o    = REQ0;
    if (en_i) begin
      if (valid_i == 2'b11) begin
        id_o    = ~ptr_i;
        grant_o = ptr_i ? 2'b01 : 2'b10;
      end else if (valid_i[0]) begin
        id_o    = REQ0;
        grant_o = 2'b01;
      end else if (valid_i[1]) begin
        id_o    = REQ1;
        grant_o = 2'b10;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/koa_mult_sched.sv
// koa_mult_sched: two-requester scheduler around one multicycle KOA_FPGA multiplier.
// Optional feature macro: KOA_SCHED_ZERO_BYPASS_EN (zero operand skips the multiplier). Revision 1.0
`default_nettype none

module koa_mult_sched
  import koa_sched_pkg::*;
#(
  parameter int SW  = 54,
  parameter int LAT = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req0_valid_i,
  output logic            req0_ready_o,
  input  logic [SW-1:0]   req0_a_i,
  input  logic [SW-1:0]   req0_b_i,
  input  logic            req1_valid_i,
  output logic            req1_ready_o,
  input  logic [SW-1:0]   req1_a_i,
  input  logic [SW-1:0]   req1_b_i,
  output logic            rsp_valid_o,
  input  logic            rsp_ready_i,
  output logic            rsp_id_o,
  output logic [2*SW-1:0] rsp_result_o,
  output logic            busy_o
);

  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LAT - 1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [SW-1:0]     a_q, a_d, b_q, b_d;
  logic              id_q, id_d;
  logic              ptr_q, ptr_d;
  logic [2*SW-1:0]   res_q, res_d;

  logic [1:0]        grant;
  logic              win_id;
  logic              hs;
  logic              zero_hit;
  logic [SW-1:0]     win_a, win_b;
  logic [2*SW-1:0]   prod;

  // Gating with rst keeps both readies low while reset is held, even if a valid is up.
  koa_rr_arb2 u_arb (
    .valid_i ({req1_valid_i, req0_valid_i}),
    .ptr_i   (ptr_q),
    .en_i    ((state_q == S_IDLE) && rst),
    .grant_o (grant),
    .id_o    (win_id)
  );

  assign hs    = |grant;
  assign win_a = (win_id == REQ1) ? req1_a_i : req0_a_i;
  assign win_b = (win_id == REQ1) ? req1_b_i : req0_b_i;

`ifdef KOA_SCHED_ZERO_BYPASS_EN
  assign zero_hit = (win_a == '0) || (win_b == '0);
`else
  assign zero_hit = 1'b0;
`endif

  // a_q/b_q -> res_q is a LAT-cycle multicycle path; timing constraints must declare it so.
  KOA_FPGA #(.SW(SW)) u_koa (
    .a_i (a_q),
    .b_i (b_q),
    .p_o (prod)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    id_d    = id_q;
    ptr_d   = ptr_q;
    res_d   = res_q;
    case (state_q)
      S_IDLE: begin
        if (hs) begin
          a_d   = win_a;
          b_d   = win_b;
          id_d  = win_id;
          ptr_d = win_id;
          if (zero_hit) begin
            res_d   = '0;
            state_d = S_DONE;
          end else begin
            cnt_d   = CNT_INIT;
            state_d = S_CALC;
          end
        end
      end
      S_CALC: begin
        if (cnt_q == '0) begin
          res_d   = prod;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_DONE: begin
        if (rsp_ready_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      id_q    <= REQ0;
      ptr_q   <= REQ1;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      id_q    <= id_d;
      ptr_q   <= ptr_d;
      res_q   <= res_d;
    end
  end

  assign req0_ready_o = grant[0];
  assign req1_ready_o = grant[1];
  assign rsp_valid_o  = (state_q == S_DONE);
  assign rsp_id_o     = id_q;
  assign rsp_result_o = res_q;
  assign busy_o       = (state_q != S_IDLE);

endmodule

`default_nettype wire
